uart_rx_fifo: RTL
=================

# uart_rx_fifo

Receive-side byte buffer sitting directly downstream of the UART receiver in `all_uart`. It captures each byte the receiver strobes out, discards bytes with framing errors, and holds up to DEPTH bytes for a consumer using a valid/ready handshake. It supports a synchronous flush (`clr`, driven from the same source as the word-clear input) and exposes fill level and sticky error flags for status LEDs.

## Interface
- `DATA_W`, 8, byte width from the receiver.
- `DEPTH`, 16, FIFO depth; power of two, ≥2.
- `clk`  in  1  system clock, single domain.
- `res`  in  1  synchronous active-high reset.
- `rx_data`  in  DATA_W  received byte, valid only with `rx_valid`.
- `rx_valid`  in  1  one-cycle strobe from receiver, at most one per cycle.
- `rx_ferr`  in  1  framing error (stop bit low), qualified by `rx_valid`.
- `clr`  in  1  synchronous flush, level; active-high.
- `out_data`  out  DATA_W  byte at FIFO head.
- `out_valid`  out  1  head byte present (= !empty).
- `out_ready`  in  1  consumer accepts head when `out_valid && out_ready`.
- `count`  out  $clog2(DEPTH)+1  stored bytes, 0..DEPTH.
- `full`  out  1  `count == DEPTH`.
- `ovf`  out  1  sticky overflow flag.
- `ferr`  out  1  sticky framing-error flag.

## Operation
- Storage: DEPTH×DATA_W array; write pointer `wp`, read pointer `rp`, each $clog2(DEPTH) bits, wrapping modulo DEPTH; `count` held as its own register.
- push = `rx_valid && !rx_ferr`; pop = `out_valid && out_ready`.
- `rx_valid && rx_ferr`: byte discarded, `ferr` set, no pointer change.
- Push, not full: `mem[wp] <= rx_data`, `wp++`, `count++`.
- Pop: `rp++`, `count--`.
- Push and pop same cycle: both performed, `count` unchanged; legal at full (pop frees the slot, no overflow) and at count 1.
- Pop when empty: impossible (`out_valid`=0); `out_ready` ignored.
- Push when full, no pop: overflow, `ovf` set; data handling per Configuration.
- `out_data` = `mem[rp]`, combinational read; content undefined (don't-care) when `out_valid`=0.
- Priority: `res` > `clr` > normal. `clr`: `wp`, `rp`, `count` ← 0, `ovf`, `ferr` ← 0; any push/pop/ferr in that cycle discarded. Memory contents not cleared.
- Flags clear only on `res` or `clr`.

## Timing
- Reset values: `out_valid`=0, `count`=0, `full`=0, `ovf`=0, `ferr`=0; `out_data` don't-care.
- Latency: push at edge N → `out_valid`=1 and `out_data` valid after edge N (cycle N+1) when previously empty. No fall-through within the same cycle.
- `count`, `full`, `ovf`, `ferr` are registered, updating on the edge that performs the event.
- Throughput: one push and one pop per cycle sustained.
- `clr` or `res` asserted mid-stream: effective at that edge; `out_valid`=0 the next cycle.

## Configuration
- `UART_RX_FIFO_OVERWRITE_EN` defined: on overflow, the oldest byte is dropped (`rp++`), the new byte is written at `wp` (`wp++`), `count` stays DEPTH, and `ovf` is set.
- Not defined (default): on overflow, the incoming byte is dropped, pointers and `count` are unchanged, and `ovf` is set.

## Test plan
- Reset, then push 0x55 with `out_ready`=0 → cycle after the push: `out_valid`=1, `out_data`=0x55, `count`=1; assert `out_ready` → `count`=0, `out_valid`=0.
- Push 0x00..0x0F (DEPTH=16), then push 0xAA → `full`=1, `ovf`=1.
  - Default build: drain yields 0x00..0x0F.
  - `UART_RX_FIFO_OVERWRITE_EN` build: drain yields 0x01..0x0F, 0xAA.
- Fill to 16, then push 0x77 and pop in the same cycle → `ovf`=0, `count`=16; last byte drained is 0x77.
- Push 0x3C with `rx_ferr`=1 → `ferr`=1, `count` unchanged; next good byte 0xC3 is stored normally.
- Fill 5 bytes with `ovf` and `ferr` set, pulse `clr` coincident with a push → `count`=0, flags cleared, pushed byte absent.
- Randomised back-to-back push/pop for 1000 cycles, pointers wrapping ≥3 times → output order matches a reference queue, `count` never exceeds 16.

Source files
------------

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Purpose  : Receive byte buffer behind the UART receiver. Framing-error bytes
//            are dropped. Overflow and framing errors are recorded in sticky
//            flags. Optional macro UART_RX_FIFO_OVERWRITE_EN selects
//            drop-oldest behaviour on overflow. The default drops the newest
//            byte.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                       clk,
    input  logic                       res,
    input  logic [DATA_W-1:0]          rx_data,
    input  logic                       rx_valid,
    input  logic                       rx_ferr,
    input  logic                       clr,
    output logic [DATA_W-1:0]          out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       ovf,
    output logic                       ferr
);

    localparam int                c_ADDR_W = $clog2(DEPTH);
    localparam int                c_CNT_W  = c_ADDR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(DEPTH);

    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [c_ADDR_W-1:0] r_wp;
    logic [c_ADDR_W-1:0] r_rp;
    logic [c_CNT_W-1:0]  r_count;
    logic                r_ovf;
    logic                r_ferr;

    logic w_push;
    logic w_pop;
    logic w_full;
    logic w_empty;
    logic w_ovf_evt;
    logic w_wr_en;
    logic w_rd_adv;

    assign w_push    = rx_valid && !rx_ferr;
    assign w_full    = (r_count == c_FULL);
    assign w_empty   = (r_count == '0);
    assign w_pop     = !w_empty && out_ready;
    // A pop in the same cycle frees the slot, so that case is not an overflow.
    assign w_ovf_evt = w_push && w_full && !w_pop;

    always_comb begin
        w_wr_en  = 1'b0;
        w_rd_adv = w_pop;
`ifdef UART_RX_FIFO_OVERWRITE_EN
        // Overwrite mode: every good byte is stored, and the oldest byte is retired on overflow.
        w_wr_en  = w_push;
        w_rd_adv = w_pop || w_ovf_evt;
`else
        w_wr_en  = w_push && !w_ovf_evt;
`endif
    end

    // Storage has no reset. Pointer reset alone makes the contents unobservable.
    always_ff @(posedge clk) begin
        if (!res && !clr && w_wr_en) begin
            r_mem[r_wp] <= rx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (res || clr) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wp <= r_wp + c_ADDR_W'(1);
            end
            if (w_rd_adv) begin
                r_rp <= r_rp + c_ADDR_W'(1);
            end
            if (w_wr_en && !w_rd_adv) begin
                r_count <= r_count + c_CNT_W'(1);
            end else if (w_rd_adv && !w_wr_en) begin
                r_count <= r_count - c_CNT_W'(1);
            end
            if (w_ovf_evt) begin
                r_ovf <= 1'b1;
            end
            if (rx_valid && rx_ferr) begin
                r_ferr <= 1'b1;
            end
        end
    end

    assign out_data  = r_mem[r_rp];
    assign out_valid = !w_empty;
    assign count     = r_count;
    assign full      = w_full;
    assign ovf       = r_ovf;
    assign ferr      = r_ferr;

endmodule
`default_nettype wire
